// File: rtl/vram_pkg.sv
// Shared types and constants for the VRAM controller: command opcodes, drain
// states, address increments and the VRAM region map.
package vram_pkg;

  localparam logic [15:0] TILE_OFFSET      = 16'h0000;
  localparam logic [15:0] NAMETABLE_OFFSET = 16'h1800;
  localparam logic [15:0] ATTR_OFFSET      = 16'h2700;
  localparam logic [15:0] PALETTE_OFFSET   = 16'h2AC0;

  // Row walk steps one byte, nametable column walk steps one 64-byte row
  localparam int INCR_ROW = 1;
  localparam int INCR_COL = 64;

  typedef enum logic [1:0] {
    ADDR_LO = 2'd0,
    ADDR_HI = 2'd1,
    WRITE   = 2'd2,
    MODE    = 2'd3
  } cpu_op_t;

  typedef enum logic {
    ST_IDLE,
    ST_DRAIN
  } drain_state_t;

endpackage

// File: rtl/vram_ctrl_if.sv
// Bus bundle between the VRAM controller and its users: the pixel processor
// fetch port and the CPU command port.
interface vram_ctrl_if;
  import vram_pkg::*;

  logic [15:0] hpu_addr;
  logic [7:0]  hpu_data;
  logic        cpu_valid;
  logic        cpu_ready;
  cpu_op_t     cpu_op;
  logic [7:0]  cpu_wdata;

  modport master (
    output hpu_addr, cpu_valid, cpu_op, cpu_wdata,
    input  hpu_data, cpu_ready
  );

  modport slave (
    input  hpu_addr, cpu_valid, cpu_op, cpu_wdata,
    output hpu_data, cpu_ready
  );

endinterface

// File: rtl/vram_wfifo.sv
// Small synchronous write FIFO holding {address, byte} entries.
// Pointers and level clear asynchronously; the storage itself is never reset.
module vram_wfifo #(
  parameter  int WIDTH = 22,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] slot_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [LVL_W-1:0] level_reg;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      slot_reg[wr_ptr_reg] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      if (push_ok && !pop_ok) begin
        level_reg <= level_reg + LVL_W'(1);
      end else if (pop_ok && !push_ok) begin
        level_reg <= level_reg - LVL_W'(1);
      end
    end
  end

  assign pop_data = slot_reg[rd_ptr_reg];
  assign full     = (level_reg == LVL_W'(DEPTH));
  assign empty    = (level_reg == '0);
  assign level    = level_reg;

endmodule

// File: rtl/vram_ctrl.sv
// VRAM responder: zero-latency fetch port plus a FIFO-buffered CPU write port.
// Define VRAM_BLANK_GATE_EN to restrict FIFO commits to display blanking.
module vram_ctrl
  import vram_pkg::*;
#(
  parameter  int DEPTH      = 16384,
  parameter  int ADDR_W     = 14,
  parameter  int FIFO_DEPTH = 4,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  vram_ctrl_if.slave       bus,
  input  logic             in_blank,
  output logic [LVL_W-1:0] fifo_level,
  output logic             busy
);

  localparam int          ENTRY_W     = ADDR_W + 8;
  localparam logic [16:0] DEPTH_LIMIT = 17'(DEPTH);

  logic [7:0]         mem [DEPTH];
  logic [ADDR_W-1:0]  addr_reg;
  logic               incr_sel_reg;
  logic               started_reg;
  drain_state_t       state_reg;

  logic               gate;
  logic               fire;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic [ADDR_W-1:0]  head_addr;
  logic [7:0]         head_data;
  logic [ADDR_W-1:0]  incr;
  logic [LVL_W-1:0]   level_after;

`ifdef VRAM_BLANK_GATE_EN
  assign gate = in_blank;
`else
  logic unused_in_blank;
  assign unused_in_blank = in_blank;
  assign gate            = 1'b1;
`endif

  assign fire       = bus.cpu_valid && bus.cpu_ready;
  assign push       = fire && (bus.cpu_op == WRITE);
  assign pop        = (state_reg == ST_DRAIN) && gate && !fifo_empty;
  assign push_entry = {addr_reg, bus.cpu_wdata};
  assign {head_addr, head_data} = head_entry;
  assign incr        = incr_sel_reg ? ADDR_W'(INCR_COL) : ADDR_W'(INCR_ROW);
  assign level_after = fifo_level + LVL_W'(push) - LVL_W'(pop);

  vram_wfifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_wfifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Ready comes purely from registers, so a pop never reopens it in the same cycle
  assign bus.cpu_ready = started_reg && !fifo_full;
  assign busy          = !fifo_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_reg     <= '0;
      incr_sel_reg <= 1'b0;
      started_reg  <= 1'b0;
    end else begin
      started_reg <= 1'b1;
      if (fire) begin
        unique case (bus.cpu_op)
          ADDR_LO: addr_reg[7:0]        <= bus.cpu_wdata;
          ADDR_HI: addr_reg[ADDR_W-1:8] <= bus.cpu_wdata[ADDR_W-9:0];
          WRITE:   addr_reg             <= addr_reg + incr;
          MODE:    incr_sel_reg         <= bus.cpu_wdata[0];
          default: ;
        endcase
      end
    end
  end

  // State looks at the post-edge level so a fresh push drains on the very next cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= ((level_after != '0) && gate) ? ST_DRAIN : ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      mem[head_addr] <= head_data;
    end
  end

  assign bus.hpu_data = ({1'b0, bus.hpu_addr} < DEPTH_LIMIT) ?
                        mem[bus.hpu_addr[ADDR_W-1:0]] : 8'h00;

endmodule

// File: tb/tb_vram_ctrl.sv
// Self-checking bench for vram_ctrl: expected commits are queued as writes are
// issued and compared through the fetch port once the FIFO has drained.
module tb_vram_ctrl;
  import vram_pkg::*;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_blank;
  logic [2:0] fifo_level;
  logic       busy;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];

  vram_ctrl_if bus ();

  vram_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus.slave),
    .in_blank   (in_blank),
    .fifo_level (fifo_level),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one command; returns 1 ns after its handshake edge
  task automatic cpu_cmd(input cpu_op_t op, input logic [7:0] d);
    int waited = 0;
    bus.cpu_valid = 1'b1;
    bus.cpu_op    = op;
    bus.cpu_wdata = d;
    @(negedge clk);
    while (!bus.cpu_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    n_tests++;
    if (bus.cpu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL cmd_accept op=%0d ready=%b required 1", op, bus.cpu_ready);
    end
    @(posedge clk);
    #1;
    bus.cpu_valid = 1'b0;
  endtask

  task automatic cpu_write(input logic [15:0] exp_addr, input logic [7:0] d);
    exp_t e;
    e.addr = exp_addr;
    e.data = d;
    sb_q.push_back(e);
    cpu_cmd(WRITE, d);
  endtask

  task automatic set_addr(input logic [15:0] a);
    cpu_cmd(ADDR_HI, a[15:8]);
    cpu_cmd(ADDR_LO, a[7:0]);
  endtask

  task automatic wait_idle(input string tag);
    int waited = 0;
    @(negedge clk);
    while (busy && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_drain busy=%b required 0", tag, busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_scoreboard(input string tag);
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      bus.hpu_addr = e.addr;
      #2;
      n_tests++;
      if (bus.hpu_data !== e.data) begin
        n_fail++;
        $display("FAIL %s_commit addr=%h got %h required %h", tag, e.addr, bus.hpu_data, e.data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    in_blank      = 1'b1;
    bus.cpu_valid = 1'b0;
    bus.cpu_op    = ADDR_LO;
    bus.cpu_wdata = 8'h00;
    bus.hpu_addr  = 16'h0000;
    #1;
    n_tests++;
    if (bus.cpu_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready got %b required 0", bus.cpu_ready);
    end
    n_tests++;
    if (fifo_level !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_level got %0d required 0", fifo_level);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy got %b required 0", busy);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.cpu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL release_ready got %b required 1", bus.cpu_ready);
    end
  endtask

  task automatic test_single_write();
    set_addr(NAMETABLE_OFFSET + 16'h0005);
    cpu_write(16'h1805, 8'h3C);
    wait_idle("prefill");
    check_scoreboard("prefill");
    bus.hpu_addr = 16'h1805;
    set_addr(16'h1805);
    bus.cpu_valid = 1'b1;
    bus.cpu_op    = WRITE;
    bus.cpu_wdata = 8'hA7;
    @(negedge clk);
    n_tests++;
    if (bus.cpu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ready got %b required 1", bus.cpu_ready);
    end
    @(posedge clk);
    #1;
    bus.cpu_valid = 1'b0;
    n_tests++;
    if (bus.hpu_data !== 8'h3C) begin
      n_fail++;
      $display("FAIL single_old_data got %h required 3c", bus.hpu_data);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.hpu_data !== 8'hA7) begin
      n_fail++;
      $display("FAIL single_new_data got %h required a7", bus.hpu_data);
    end
    cpu_write(16'h1806, 8'h5B);
    wait_idle("single");
    check_scoreboard("single_next_addr");
  endtask

  task automatic test_incr_modes();
    logic [15:0] col_addr [4];
    col_addr = '{16'h1800, 16'h1840, 16'h1880, 16'h18C0};
    set_addr(NAMETABLE_OFFSET);
    cpu_cmd(MODE, 8'h01);
    for (int i = 0; i < 4; i++) begin
      cpu_write(col_addr[i], 8'(i + 1));
    end
    n_tests++;
    if (fifo_level !== 3'd1) begin
      n_fail++;
      $display("FAIL stream_level got %0d required 1", fifo_level);
    end
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL stream_busy got %b required 1", busy);
    end
    cpu_cmd(MODE, 8'h00);
    cpu_write(16'h1900, 8'h05);
    cpu_write(16'h1901, 8'h06);
    wait_idle("incr");
    check_scoreboard("incr");
  endtask

  task automatic test_wrap();
    cpu_cmd(ADDR_HI, 8'hFF);
    cpu_cmd(ADDR_LO, 8'hFF);
    cpu_write(16'h3FFF, 8'h11);
    cpu_write(16'h0000, 8'h22);
    cpu_cmd(MODE, 8'h01);
    set_addr(16'h3FF0);
    cpu_write(16'h3FF0, 8'h33);
    cpu_write(16'h0030, 8'h44);
    cpu_cmd(MODE, 8'h00);
    wait_idle("wrap");
    check_scoreboard("wrap");
  endtask

  task automatic test_out_of_range();
    logic [15:0] addrs [5];
    logic [7:0]  exps  [5];
    addrs = '{16'h8000, 16'h4000, 16'hFFFF, 16'hC030, 16'h3FFF};
    exps  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h11};
    for (int i = 0; i < 5; i++) begin
      bus.hpu_addr = addrs[i];
      #2;
      n_tests++;
      if (bus.hpu_data !== exps[i]) begin
        n_fail++;
        $display("FAIL range_read addr=%h got %h required %h", addrs[i], bus.hpu_data, exps[i]);
      end
    end
    @(posedge clk);
    #1;
  endtask

`ifdef VRAM_BLANK_GATE_EN
  task automatic test_blank_gate();
    logic [2:0] lvl_exp [7];
    exp_t       e;
    int         accepted = 0;
    logic       acc;
    lvl_exp = '{3'd4, 3'd4, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
    set_addr(PALETTE_OFFSET);
    cpu_write(PALETTE_OFFSET, 8'h77);
    wait_idle("gate_prefill");
    check_scoreboard("gate_prefill");
    in_blank = 1'b0;
    set_addr(PALETTE_OFFSET);
    for (int i = 0; i < 4; i++) begin
      cpu_write(PALETTE_OFFSET + 16'(i), 8'hE1 + 8'(i));
    end
    @(negedge clk);
    n_tests++;
    if (fifo_level !== 3'd4) begin
      n_fail++;
      $display("FAIL gate_full_level got %0d required 4", fifo_level);
    end
    bus.hpu_addr = PALETTE_OFFSET;
    #1;
    n_tests++;
    if (bus.hpu_data !== 8'h77) begin
      n_fail++;
      $display("FAIL gate_no_commit got %h required 77", bus.hpu_data);
    end
    e.addr = PALETTE_OFFSET + 16'd4;
    e.data = 8'hE5;
    sb_q.push_back(e);
    bus.cpu_valid = 1'b1;
    bus.cpu_op    = WRITE;
    bus.cpu_wdata = 8'hE5;
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if (bus.cpu_ready !== 1'b0 || fifo_level !== 3'd4) begin
        n_fail++;
        $display("FAIL gate_stall ready=%b level=%0d required 0 and 4", bus.cpu_ready, fifo_level);
      end
    end
    @(posedge clk);
    #1;
    in_blank = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      n_tests++;
      if (fifo_level !== lvl_exp[i]) begin
        n_fail++;
        $display("FAIL gate_drain_level step=%0d got %0d required %0d", i, fifo_level, lvl_exp[i]);
      end
      acc = bus.cpu_valid && bus.cpu_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        bus.cpu_valid = 1'b0;
        accepted++;
      end
    end
    n_tests++;
    if (accepted != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL gate_fifth accepted=%0d busy=%b required 1 and 0", accepted, busy);
    end
    check_scoreboard("gate");
  endtask
`endif

  task automatic test_reset_mid_burst();
    exp_t e;
    logic [15:0] addrs [3];
    logic [7:0]  exps  [3];
    addrs = '{16'h2700, 16'h2740, 16'h2780};
`ifdef VRAM_BLANK_GATE_EN
    exps = '{8'hA0, 8'hA1, 8'hA2};
`else
    exps = '{8'hB0, 8'hB1, 8'hA2};
`endif
    cpu_cmd(MODE, 8'h01);
    set_addr(ATTR_OFFSET);
    for (int i = 0; i < 3; i++) begin
      cpu_write(addrs[i], 8'hA0 + 8'(i));
    end
    wait_idle("burst_prefill");
    check_scoreboard("burst_prefill");
`ifdef VRAM_BLANK_GATE_EN
    in_blank = 1'b0;
`endif
    set_addr(ATTR_OFFSET);
    cpu_cmd(WRITE, 8'hB0);
    cpu_cmd(WRITE, 8'hB1);
    cpu_cmd(WRITE, 8'hB2);
    #1;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (fifo_level !== 3'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_level level=%0d busy=%b required 0 and 0", fifo_level, busy);
    end
    n_tests++;
    if (bus.cpu_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_ready got %b required 0", bus.cpu_ready);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.cpu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_release_ready got %b required 1", bus.cpu_ready);
    end
`ifdef VRAM_BLANK_GATE_EN
    in_blank = 1'b1;
`endif
    for (int i = 0; i < 3; i++) begin
      e.addr = addrs[i];
      e.data = exps[i];
      sb_q.push_back(e);
    end
    check_scoreboard("midreset_mem");
  endtask

  task automatic test_post_reset();
    cpu_write(TILE_OFFSET, 8'h5A);
    cpu_write(TILE_OFFSET + 16'd1, 8'h5B);
    wait_idle("post_reset");
    check_scoreboard("post_reset_addr");
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_incr_modes();
    test_wrap();
    test_out_of_range();
`ifdef VRAM_BLANK_GATE_EN
    test_blank_gate();
`endif
    test_reset_mid_burst();
    test_post_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
